// File: rtl/instr_driver.sv
// instr_driver: host-side initiator for the two-unit compute chip pin interface.
// Instructions arrive on a ready/valid stream, queue in a small FIFO, and are
// driven one at a time onto the chip's ui_in/uio_in pins. The chip's uo_out is
// sampled a fixed number of cycles later and returned as a tagged response.
// Optional feature: define INSTR_DRV_CONTENTION_CHK_EN to enable the sticky
// uio contention detector; otherwise contention_err is tied low.
module instr_driver #(
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr_data,
  output logic [7:0]  chip_ui_in,
  output logic [7:0]  chip_uio_in,
  input  logic [7:0]  chip_uo_out,
  input  logic [7:0]  chip_uio_oe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic        contention_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CntW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wrPtr_q, wrPtr_d;
  logic [AW:0]       rdPtr_q, rdPtr_d;
  logic [15:0]       fifoMem [DEPTH];
  logic [CntW-1:0]   waitCnt_q, waitCnt_d;
  logic [7:0]        uiPins_q, uiPins_d;
  logic [7:0]        uioPins_q, uioPins_d;
  logic [3:0]        tag_q, tag_d;
  logic              rspValid_q, rspValid_d;
  logic [7:0]        rspData_q, rspData_d;

  logic              fifoEmpty;
  logic              fifoFull;
  logic              push;
  logic              pop;
  logic [15:0]       headData;

  // FIFO status comes purely from the pointer registers, so instr_ready never
  // depends combinationally on instr_valid.
  always_comb begin
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    push      = instr_valid && !fifoFull;
    headData  = fifoMem[rdPtr_q[AW-1:0]];
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifoMem[wrPtr_q[AW-1:0]] <= instr_data;
    end
  end

  // Next-state and datapath decode for the issue/wait/response sequence.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    uiPins_d   = uiPins_q;
    uioPins_d  = uioPins_q;
    tag_d      = tag_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifoEmpty && ena) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        waitCnt_d = CntW'(RESP_LAT - 1);
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          rspData_d  = chip_uo_out;
          rspValid_d = 1'b1;
          uiPins_d   = 8'h00;
          uioPins_d  = 8'h00;
          state_d    = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          if (!fifoEmpty && ena) begin
            state_d = ISSUE;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      uiPins_d  = headData[7:0];
      uioPins_d = headData[15:8];
      tag_d     = headData[11:8];
    end
  end

  // Pointer advance: push and pop in the same cycle leave the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  // State and datapath registers; reset discards queued and in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      waitCnt_q  <= '0;
      uiPins_q   <= 8'h00;
      uioPins_q  <= 8'h00;
      tag_q      <= 4'h0;
      rspValid_q <= 1'b0;
      rspData_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      waitCnt_q  <= waitCnt_d;
      uiPins_q   <= uiPins_d;
      uioPins_q  <= uioPins_d;
      tag_q      <= tag_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

  assign instr_ready = !fifoFull;
  assign chip_ui_in  = uiPins_q;
  assign chip_uio_in = uioPins_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_data    = rspData_q;
  assign rsp_tag     = tag_q;
  assign busy        = (state_q != IDLE) || !fifoEmpty;

`ifdef INSTR_DRV_CONTENTION_CHK_EN
  logic contention_q, contention_d;

  // Flag any bit the chip drives while we also drive it high during an issue.
  always_comb begin
    contention_d = contention_q;
    if (((state_q == ISSUE) || (state_q == WAIT)) &&
        ((chip_uio_oe & uioPins_q) != 8'h00)) begin
      contention_d = 1'b1;
    end
  end

  // Sticky contention flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contention_q <= 1'b0;
    end else begin
      contention_q <= contention_d;
    end
  end

  assign contention_err = contention_q;
`else
  logic unusedOe;
  assign unusedOe       = ^chip_uio_oe;
  assign contention_err = 1'b0;
`endif

endmodule
